// File: rtl/div_seq.sv
// Purpose : restoring radix-2 sequential divider for DIV/DIVU, one quotient bit per clock.
// Latency : start sampled at edge k -> ready_o after edge k+WIDTH+1; divide-by-zero after edge k+1.
// Backpr. : none internal; the requester holds start_i (and stalls) until ready_o, then drops start_i.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   signed_div_i             1 = signed (DIV), 0 = unsigned (DIVU)
//   opdata1_i / opdata2_i    dividend / divisor, latched when the op is accepted
//   start_i                  request/hold, only looked at in FREE and END
//   annul_i                  abandons an op that is in progress (ON only)
//   result_o                 {remainder, quotient}, valid while ready_o=1
//   ready_o                  result valid
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LP_LAST = CW'(WIDTH);

    typedef enum logic [1:0] {
        S_FREE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    // r_dq starts as |dividend|; each step shifts its MSB into the partial
    // remainder and the new quotient bit into its LSB, so after WIDTH steps
    // it holds the unsigned quotient.
    logic [WIDTH-1:0]     r_dq;
    logic [WIDTH-1:0]     r_dvs;
    logic [WIDTH-1:0]     r_rem;
    logic                 r_sa;
    logic                 r_sb;
    logic                 r_sgn;
    logic [2*WIDTH-1:0]   r_result;
    logic                 r_ready;

    logic                 w_sa;
    logic                 w_sb;
    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic [WIDTH:0]       w_part;
    logic                 w_ge;
    logic [WIDTH-1:0]     w_rem_next;
    logic [WIDTH-1:0]     w_quot_fix;
    logic [WIDTH-1:0]     w_rem_fix;

    // Operand magnitudes: only negated when dividing signed and MSB is set.
    // The most negative value negates to itself, which reads correctly as an
    // unsigned magnitude of 2^(WIDTH-1).
    assign w_sa    = signed_div_i & opdata1_i[WIDTH-1];
    assign w_sb    = signed_div_i & opdata2_i[WIDTH-1];
    assign w_abs_a = w_sa ? (~opdata1_i + 1'b1) : opdata1_i;
    assign w_abs_b = w_sb ? (~opdata2_i + 1'b1) : opdata2_i;

    // Partial remainder is one bit wider than the divisor so the compare
    // cannot overflow; after a subtract the result is always < divisor and
    // fits back in WIDTH bits.
    assign w_part     = {r_rem, r_dq[WIDTH-1]};
    assign w_ge       = (w_part >= {1'b0, r_dvs});
    assign w_rem_next = w_ge ? (w_part[WIDTH-1:0] - r_dvs) : w_part[WIDTH-1:0];

    // Quotient sign is the XOR of operand signs; remainder follows dividend.
    assign w_quot_fix = (r_sgn & (r_sa ^ r_sb)) ? (~r_dq + 1'b1) : r_dq;
    assign w_rem_fix  = (r_sgn & r_sa) ? (~r_rem + 1'b1) : r_rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_FREE;
            r_cnt    <= '0;
            r_dq     <= '0;
            r_dvs    <= '0;
            r_rem    <= '0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_sgn    <= 1'b0;
            r_result <= '0;
            r_ready  <= 1'b0;
        end else begin
            case (r_state)
                S_FREE: begin
                    r_ready  <= 1'b0;
                    r_result <= '0;
                    if (start_i && !annul_i) begin
                        if (opdata2_i == '0) begin
                            r_state <= S_BYZERO;
                        end else begin
                            r_dq    <= w_abs_a;
                            r_dvs   <= w_abs_b;
                            r_rem   <= '0;
                            r_sa    <= w_sa;
                            r_sb    <= w_sb;
                            r_sgn   <= signed_div_i;
                            r_cnt   <= '0;
                            r_state <= S_ON;
                        end
                    end
                end

                S_BYZERO: begin
                    r_result <= '0;
                    r_ready  <= 1'b1;
                    r_state  <= S_END;
                end

                S_ON: begin
                    if (annul_i) begin
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        r_state <= S_FREE;
                    end else if (r_cnt != LP_LAST) begin
                        r_rem <= w_rem_next;
                        r_dq  <= {r_dq[WIDTH-2:0], w_ge};
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        r_result <= {w_rem_fix, w_quot_fix};
                        r_ready  <= 1'b1;
                        r_state  <= S_END;
                    end
                end

                S_END: begin
                    // Result is held as long as the requester keeps start_i up;
                    // dropping it is the handshake that frees the unit.
                    if (!start_i) begin
                        r_ready  <= 1'b0;
                        r_result <= '0;
                        r_state  <= S_FREE;
                    end
                end

                default: begin
                    r_state <= S_FREE;
                end
            endcase
        end
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;

endmodule
